// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes
// and the datapath select codes used by Control_Unit and ALU control.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EX, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States whose exit into FETCH retires an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
               (s == S_ADDI_WB) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute, counts retired
// instructions and flags undefined opcodes.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int         COUNT_W = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDest,
    output logic               MemToReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSource,
    output logic               busy,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    state_t               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // A parameterised halt opcode takes precedence over the fixed decode.
                if (opcode == HALT_OP) state_d = S_HALT;
                else begin
                    case (opcode)
                        OP_RTYPE:     state_d = S_R_EX;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EX:     state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b0;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_FETCH && is_retire_state(state_q))
            cnt_d = cnt_q + COUNT_W'(1);
    end

    // Output decode. The three write strobes tied to a memory completion are
    // qualified by mem_ready so they fire only in the completing cycle.
    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDest     = 1'b0;
        MemToReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALUOP_ADD;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = SRCB_IMMSH;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = mem_ready;
            end
            S_R_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDest  = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule
